step_dir_shaper: RTL and testbench
==================================

Name: step_dir_shaper

Overview:
- Sits directly downstream of each stepgen, between the raw step/dir pair and the conduit pins driving the stepper drivers.
- Converts raw step edges into driver-legal pulses with programmable dir-setup, step-high and step-low times.
- Buffers one pending step and flags overruns.
- Keeps a signed position count of the steps actually emitted, so software can read back where the motor really is.

Parameters:
- CNT_W, 16: width of the timing registers, in clk cycles.
- POS_W, 32: width of the position counter.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- en  in  1  shaper enable; 0 aborts activity.
- step_in  in  1  raw step from the stepgen; the rising edge is the request.
- dir_in  in  1  raw direction, sampled with the request.
- dir_setup  in  CNT_W  cycles dir_out must be stable before a step rises.
- step_high  in  CNT_W  step pulse width in cycles; 0 is treated as 1.
- step_low  in  CNT_W  minimum low time after a pulse, in cycles.
- clr_overrun  in  1  clears the overrun flag.
- pos_clear  in  1  zeroes the position counter.
- step_out  out  1  shaped step to the driver.
- dir_out  out  1  shaped direction to the driver.
- busy  out  1  high when the FSM is not IDLE or a step is pending.
- overrun  out  1  sticky; set when a request is dropped.
- position  out  POS_W  signed count of emitted steps.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: step_out=0, dir_out=0, overrun=0, position=0, pending empty, FSM=IDLE, step_in edge register=0.
- Request: req = step_in & ~step_in_q. dir_in is captured in the same cycle as req.
- FSM states: IDLE, SETUP, HIGH, LOW. A down-counter is loaded on each state entry. Timing inputs are sampled only at state entry, so changing them mid-state has no effect until the next entry.
- IDLE: the source is the pending entry if one is held, otherwise a req in this cycle.
  - If the source dir differs from dir_out and dir_setup>0: dir_out <= source dir, go to SETUP with count = dir_setup.
  - Otherwise: dir_out <= source dir, go to HIGH, step_out <= 1.
- SETUP: when the count expires, go to HIGH and set step_out=1.
  - Dir change, dir_setup=D: step_out rises exactly D cycles after dir_out changes.
  - Same dir: step_out rises 1 cycle after step_in is first sampled high.
- HIGH: step_out stays 1 for max(step_high,1) cycles. Then step_out <= 0 and go to LOW, or to IDLE if step_low=0.
- LOW: lasts step_low cycles, then go to IDLE. A pending step is launched from IDLE on the next edge.
- Direction: dir_out changes only on the IDLE exit edge, so it is held through HIGH and LOW.
- Position: updated on the same edge step_out rises; +1 if dir_out=1, −1 if dir_out=0. It wraps modulo 2^POS_W.
  - pos_clear has priority over the increment in the same cycle; position becomes 0 and that step is lost from the count.
- Pending buffer: one entry holding a dir bit.
  - A req arriving while not IDLE is stored if the buffer is empty.
  - A req arriving while the buffer is full is dropped and overrun is set.
  - If the IDLE exit consumes the pending entry and a req arrives in the same cycle, the req fills the freed entry and is not dropped.
  - overrun: set has priority over clr_overrun in the same cycle.
- en=0: on the next edge, FSM=IDLE, step_out=0, pending cleared, and req is ignored. dir_out and position hold. overrun is unaffected.
  - A pulse in flight is truncated. Firmware must only drop en while busy=0.
- Reset mid-pulse: all state returns to reset values on the next edge.
- Minimum step period = dir_setup (on a dir change only) + max(step_high,1) + step_low + 1 cycles.

Decomposition:
- Shared package cnc_pkg holds:
  - the FSM state enum (ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW);
  - the default timing constants for 50 MHz: DIR_SETUP_DEF=100, STEP_HIGH_DEF=100, STEP_LOW_DEF=100.
- Sub-module edge_detect_rise (1-bit registered rising-edge detector). It is reused later for igpio inputs.
- The FSM, pending buffer and position counter stay in this module.

Test Plan:
1. Single step, same dir: dir_setup=4, step_high=5, step_low=3, dir_in=0, dir_out=0, one step_in pulse → step_out high 1 cycle after the edge for 5 cycles; position=−1; busy low 9 cycles after the edge.
2. Dir change: dir_in=1 while dir_out=0, dir_setup=4 → dir_out rises on the edge after req; step_out rises 4 cycles later; position=+1.
3. Back-to-back: step_in edges 2 cycles apart, high=5, low=3 → second pulse starts exactly 1 cycle after LOW ends; no overrun; position=±2.
4. Overrun: three edges within one pulse → two pulses emitted, overrun=1; clr_overrun pulse clears it; clr_overrun and a new drop in the same cycle leave overrun=1.
5. Zero timings: step_high=0, step_low=0, dir_setup=0, edges every 3 cycles → 1-cycle pulses; dir change gives no SETUP delay.
6. Abort/wrap: en=0 mid-HIGH → step_out=0 next edge, pending cleared, dir_out held. Separately, preload position to 0x7FFFFFFF via steps, then one +step → 0x80000000. pos_clear coincident with a step edge → 0.

Source files
------------

// File: rtl/cnc_pkg.sv
// Shared types and default timing constants for the CNC step/dir path.
// The defaults assume a 50 MHz clk.
package cnc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } shaper_state_e;

   // 2 us at 50 MHz
   localparam int unsigned DIR_SETUP_DEF = 100;
   localparam int unsigned STEP_HIGH_DEF = 100;
   localparam int unsigned STEP_LOW_DEF  = 100;

endpackage

// File: rtl/edge_detect_rise.sv
// One-bit registered rising-edge detector.
// The rise output is combinational from d and the registered copy of d.
module edge_detect_rise (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic sig_q;
   logic sig_d;

   always_comb begin
      sig_d = d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign rise = d & ~sig_q;

endmodule

// File: rtl/step_dir_shaper.sv
// Turns raw stepgen step/dir into driver-legal pulses, with a one-deep pending
// buffer, a sticky overrun flag and a signed count of the steps actually emitted.
//
// state    | meaning
// ST_IDLE  | waiting; launches the pending entry first, otherwise a new request
// ST_SETUP | dir_out changed, holding step_out low for dir_setup cycles
// ST_HIGH  | step_out high for max(step_high,1) cycles
// ST_LOW   | step_out low for step_low cycles before the next launch
module step_dir_shaper
   import cnc_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int POS_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             step_in,
   input  logic             dir_in,
   input  logic [CNT_W-1:0] dir_setup,
   input  logic [CNT_W-1:0] step_high,
   input  logic [CNT_W-1:0] step_low,
   input  logic             clr_overrun,
   input  logic             pos_clear,
   output logic             step_out,
   output logic             dir_out,
   output logic             busy,
   output logic             overrun,
   output logic [POS_W-1:0] position
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   shaper_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic             pend_v_q, pend_v_d;
   logic             pend_dir_q, pend_dir_d;
   logic             ovr_q, ovr_d;
   logic [POS_W-1:0] pos_q, pos_d;

   logic             req;
   logic             src_v;
   logic             src_dir;
   logic             pend_take;
   logic             direct_take;
   logic             rise;
   logic             drop;
   logic [CNT_W-1:0] high_len;

   edge_detect_rise u_step_edge (
      .clk   (clk),
      .reset (reset),
      .d     (step_in),
      .rise  (req)
   );

   assign high_len = (step_high == '0) ? CNT_ONE : step_high;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      step_d      = step_q;
      dir_d       = dir_q;
      pend_v_d    = pend_v_q;
      pend_dir_d  = pend_dir_q;
      ovr_d       = ovr_q;
      pos_d       = pos_q;
      src_v       = 1'b0;
      src_dir     = dir_q;
      pend_take   = 1'b0;
      direct_take = 1'b0;
      rise        = 1'b0;
      drop        = 1'b0;

      if (!en) begin
         // Abort: requests are ignored, dir_out and position hold.
         state_d  = ST_IDLE;
         step_d   = 1'b0;
         pend_v_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pend_v_q) begin
                  src_v     = 1'b1;
                  src_dir   = pend_dir_q;
                  pend_take = 1'b1;
               end else if (req) begin
                  src_v       = 1'b1;
                  src_dir     = dir_in;
                  direct_take = 1'b1;
               end
               if (src_v) begin
                  dir_d = src_dir;
                  if ((src_dir != dir_q) && (dir_setup != '0)) begin
                     state_d = ST_SETUP;
                     cnt_d   = dir_setup;
                  end else begin
                     state_d = ST_HIGH;
                     cnt_d   = high_len;
                     step_d  = 1'b1;
                     rise    = 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               if (cnt_q <= CNT_ONE) begin
                  state_d = ST_HIGH;
                  cnt_d   = high_len;
                  step_d  = 1'b1;
                  rise    = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (cnt_q <= CNT_ONE) begin
                  step_d = 1'b0;
                  if (step_low == '0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_LOW;
                     cnt_d   = step_low;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_LOW: begin
               if (cnt_q <= CNT_ONE) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               step_d  = 1'b0;
            end
         endcase

         // A request freed by the IDLE launch refills the slot instead of dropping.
         if (pend_take) begin
            pend_v_d = 1'b0;
         end
         if (req && !direct_take) begin
            if (!pend_v_q || pend_take) begin
               pend_v_d   = 1'b1;
               pend_dir_d = dir_in;
            end else begin
               drop = 1'b1;
            end
         end

         if (rise) begin
            pos_d = dir_d ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
         end
      end

      if (drop) begin
         ovr_d = 1'b1;
      end else if (clr_overrun) begin
         ovr_d = 1'b0;
      end

      if (pos_clear) begin
         pos_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         step_q     <= 1'b0;
         dir_q      <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_dir_q <= 1'b0;
         ovr_q      <= 1'b0;
         pos_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         pend_v_q   <= pend_v_d;
         pend_dir_q <= pend_dir_d;
         ovr_q      <= ovr_d;
         pos_q      <= pos_d;
      end
   end

   assign step_out = step_q;
   assign dir_out  = dir_q;
   assign busy     = (state_q != ST_IDLE) | pend_v_q;
   assign overrun  = ovr_q;
   assign position = pos_q;

endmodule

// File: tb/tb_step_dir_shaper.sv
// Self-checking bench for step_dir_shaper: directed scenarios plus random traffic,
// compared every cycle against a timeline model of each emitted pulse.
module tb_step_dir_shaper;

   localparam int CNT_W = 16;
   localparam int POS_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic             step_in;
   logic             dir_in;
   logic [CNT_W-1:0] dir_setup;
   logic [CNT_W-1:0] step_high;
   logic [CNT_W-1:0] step_low;
   logic             clr_overrun;
   logic             pos_clear;
   logic             step_out;
   logic             dir_out;
   logic             busy;
   logic             overrun;
   logic [POS_W-1:0] position;

   int n_checks = 0;
   int n_fail   = 0;

   step_dir_shaper #(.CNT_W(CNT_W), .POS_W(POS_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .step_in     (step_in),
      .dir_in      (dir_in),
      .dir_setup   (dir_setup),
      .step_high   (step_high),
      .step_low    (step_low),
      .clr_overrun (clr_overrun),
      .pos_clear   (pos_clear),
      .step_out    (step_out),
      .dir_out     (dir_out),
      .busy        (busy),
      .overrun     (overrun),
      .position    (position)
   );

   always #5 clk = ~clk;

   // Model: each launched pulse is a timeline (rise edge, fall edge, end edge).
   int               m_e = 0;
   int               m_rise = -1;
   int               m_fall = -1;
   int               m_end = -1;
   logic             m_prev = 1'b0;
   logic             m_dir = 1'b0;
   logic             m_pend_v = 1'b0;
   logic             m_pend_d = 1'b0;
   logic             m_ovr = 1'b0;
   logic [POS_W-1:0] m_pos = '0;
   int               edge_cnt = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, m_e);
      end
   endtask

   task automatic m_launch(input logic d);
      int s;
      int h;
      s = ((d != m_dir) && (dir_setup != 0)) ? int'(dir_setup) : 0;
      h = (step_high == 0) ? 1 : int'(step_high);
      m_rise = m_e + s;
      m_fall = m_rise + h;
      m_end  = m_fall + int'(step_low);
      m_dir  = d;
   endtask

   task automatic model_step();
      logic req;
      logic drop;
      m_e  = edge_cnt;
      edge_cnt++;
      req  = step_in && !m_prev;
      drop = 1'b0;
      m_prev = step_in;
      if (reset) begin
         m_prev   = 1'b0;
         m_rise   = -1;
         m_fall   = -1;
         m_end    = m_e;
         m_dir    = 1'b0;
         m_pend_v = 1'b0;
         m_ovr    = 1'b0;
         m_pos    = '0;
      end else begin
         if (!en) begin
            m_rise   = -1;
            m_fall   = -1;
            m_end    = m_e;
            m_pend_v = 1'b0;
         end else begin
            if (m_e > m_end) begin
               if (m_pend_v) begin
                  m_launch(m_pend_d);
                  m_pend_v = 1'b0;
                  if (req) begin
                     m_pend_v = 1'b1;
                     m_pend_d = dir_in;
                  end
               end else if (req) begin
                  m_launch(dir_in);
               end
            end else if (req) begin
               if (!m_pend_v) begin
                  m_pend_v = 1'b1;
                  m_pend_d = dir_in;
               end else begin
                  drop = 1'b1;
               end
            end
            if (m_rise == m_e) m_pos = m_dir ? m_pos + 1'b1 : m_pos - 1'b1;
         end
         if (drop) m_ovr = 1'b1;
         else if (clr_overrun) m_ovr = 1'b0;
         if (pos_clear) m_pos = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk_eq("step_out", step_out, (m_rise <= m_e) && (m_e < m_fall));
      chk_eq("dir_out", dir_out, m_dir);
      chk_eq("busy", busy, (m_e < m_end) || m_pend_v);
      chk_eq("overrun", overrun, m_ovr);
      chk_eq("position", position, m_pos);
   endtask

   task automatic edge_in(input logic d);
      step_in = 1'b1;
      dir_in  = d;
      tick();
      step_in = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) tick();
      chk_eq("idle_timeout", busy, 1'b0);
   endtask

   task automatic set_timing(input int ds, input int sh, input int sl);
      dir_setup = CNT_W'(ds);
      step_high = CNT_W'(sh);
      step_low  = CNT_W'(sl);
   endtask

   initial begin
      int n;
      reset = 1'b1; en = 1'b1; step_in = 1'b0; dir_in = 1'b0;
      clr_overrun = 1'b0; pos_clear = 1'b0;
      set_timing(4, 5, 3);
      tick(); tick();
      reset = 1'b0;
      tick();

      // 1: single step, same direction
      step_in = 1'b1; dir_in = 1'b0;
      tick();
      chk_eq("t1_rise", step_out, 1'b1);
      step_in = 1'b0;
      n = 1;
      while (busy && n < 40) begin tick(); n++; end
      chk_eq("t1_busy_len", n, 9);
      chk_eq("t1_pos", position, 8'hFF);

      // 2: direction change, setup delay 4
      step_in = 1'b1; dir_in = 1'b1;
      tick();
      chk_eq("t2_dir", dir_out, 1'b1);
      step_in = 1'b0;
      n = 0;
      while (!step_out && n < 20) begin tick(); n++; end
      chk_eq("t2_setup_delay", n, 4);
      wait_idle(40);
      chk_eq("t2_pos", position, 8'h00);

      // 3: back-to-back edges 2 cycles apart
      edge_in(1'b1);
      edge_in(1'b1);
      wait_idle(60);
      chk_eq("t3_ovr", overrun, 1'b0);
      chk_eq("t3_pos", position, 8'h02);

      // 4: overrun, clear, and set-beats-clear
      edge_in(1'b1); edge_in(1'b1); edge_in(1'b1);
      wait_idle(60);
      chk_eq("t4_ovr_set", overrun, 1'b1);
      chk_eq("t4_pos", position, 8'h04);
      clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
      chk_eq("t4_ovr_clr", overrun, 1'b0);
      edge_in(1'b0); edge_in(1'b0);
      step_in = 1'b1; clr_overrun = 1'b1; tick();
      step_in = 1'b0; clr_overrun = 1'b0;
      chk_eq("t4_ovr_prio", overrun, 1'b1);
      wait_idle(80);

      // 5: zero timings, alternating directions every 3 cycles
      set_timing(0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         edge_in(i[0]);
         tick();
      end
      chk_eq("t5_ovr", overrun, 1'b1);

      // 6a: abort mid-HIGH with a pending entry
      set_timing(2, 8, 3);
      n = int'(dir_out);
      edge_in(dir_out);
      edge_in(dir_out);
      en = 1'b0; tick();
      chk_eq("t6_abort_step", step_out, 1'b0);
      chk_eq("t6_abort_busy", busy, 1'b0);
      chk_eq("t6_abort_dir", dir_out, n[0]);
      en = 1'b1; tick();

      // 6b: wrap at 2^(POS_W-1), then pos_clear against a step
      set_timing(0, 0, 0);
      pos_clear = 1'b1; tick(); pos_clear = 1'b0;
      for (int i = 0; i < 127; i++) edge_in(1'b1);
      chk_eq("t6_pos_max", position, 8'h7F);
      edge_in(1'b1);
      chk_eq("t6_pos_wrap", position, 8'h80);
      step_in = 1'b1; dir_in = 1'b1; pos_clear = 1'b1; tick();
      step_in = 1'b0; pos_clear = 1'b0;
      chk_eq("t6_pos_clear", position, 8'h00);
      wait_idle(20);

      // random traffic
      for (int i = 0; i < 5000; i++) begin
         if (!busy && $urandom_range(0, 15) == 0)
            set_timing($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
         step_in     = ($urandom_range(0, 3) == 0);
         dir_in      = $urandom_range(0, 1) == 1;
         clr_overrun = ($urandom_range(0, 40) == 0);
         pos_clear   = ($urandom_range(0, 200) == 0);
         en          = ($urandom_range(0, 150) != 0);
         reset       = ($urandom_range(0, 800) == 0);
         tick();
      end
      reset = 1'b0; en = 1'b1; step_in = 1'b0; clr_overrun = 1'b0; pos_clear = 1'b0;
      wait_idle(100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
